bht_resolve_queue: RTL and testbench
====================================

// Module: bht_resolve_queue
// PURPOSE
//  In-order tracker of fetch-time branch predictions between IF lookup and EX resolution.
//  IF pushes each instruction's prediction (pc_4, guessed next PC, BHT state); EX resolves in order.
//  The resolved head drives the BHT update port (update_en/update_pc_4/.../branch_succ) one cycle later.
//  Mispredicts raise a redirect to the fetch PC mux.
// PARAMETERS
//  ADDR_W   `IM_ADDR_BIT  width of instruction word address (pc_4, targets)
//  DEPTH    4             in-flight entries; power of two, >= 2
//  CNT_W    3             width of count, = log2(DEPTH)+1
// PORTS
//  clk             in   1       clock, all state on posedge
//  rst             in   1       synchronous active-high reset
//  push_valid      in   1       IF offers a prediction record
//  push_ready      out  1       queue can accept; = (count < DEPTH), combinational from registers
//  push_pc_4       in   ADDR_W  fall-through PC of fetched instruction
//  push_guess_pc   in   ADDR_W  predicted next PC (BHT guess_new_pc)
//  push_guess_st   in   2       BHT guess_state at lookup
//  flush           in   1       pipeline kill; empties queue
//  res_valid       in   1       EX resolves oldest entry this cycle
//  res_is_branch   in   1       resolved instruction is a conditional branch
//  res_taken       in   1       branch outcome (ignored if !res_is_branch)
//  res_target      in   ADDR_W  taken target
//  upd_en          out  1       BHT update strobe (registered)
//  upd_pc_4        out  ADDR_W  to update_pc_4
//  upd_pc_remote   out  ADDR_W  to update_pc_remote
//  upd_state_old   out  2       to update_state_old
//  upd_succ        out  1       to branch_succ
//  redirect_valid  out  1       mispredict, refetch (registered, 1-cycle pulse)
//  redirect_pc     out  ADDR_W  correct next PC
//  count           out  CNT_W   occupied entries
//  err_underflow   out  1       sticky: res_valid while empty
// BEHAVIOUR
//  Reset (rst=1 at posedge): head=tail=count=0; all outputs 0 except push_ready=1; err cleared.
//  Storage: circular buffer {pc_4, guess_pc, guess_st}; head/tail wrap modulo DEPTH.
//  Push accepted iff push_valid && push_ready && !flush && !mispredict_now. Written at tail, tail+1.
//  Full: push_ready=0 even if a pop happens the same cycle (no bypass).
//  Resolve iff res_valid && count!=0 && !flush. Uses head entry H:
//   actual = (res_is_branch && res_taken) ? res_target : H.pc_4
//   mispredict_now = (actual != H.guess_pc)
//  Next cycle (latency 1, registered): upd_en = res_is_branch; upd_pc_4=H.pc_4;
//   upd_pc_remote = res_taken ? res_target : H.guess_pc; upd_state_old=H.guess_st;
//   upd_succ=res_taken; redirect_valid=mispredict_now; redirect_pc=actual.
//  Outputs hold last value with upd_en/redirect_valid=0 in non-resolve cycles.
//  Correct resolve: head+1, count-1 (+1 if simultaneous push -> count unchanged).
//  Mispredict resolve: all entries (wrong-path) discarded; head=tail, count=0; same-cycle push dropped.
//  flush: head=tail, count=0; same-cycle push and resolve ignored; next-cycle upd_en=redirect_valid=0.
//  Priority: rst > flush > resolve > push.
//  res_valid with count==0: ignored, no update, err_underflow<=1 until rst.
//  Non-branch resolve with guess_pc != pc_4 (BHT alias): redirect to pc_4, upd_en=0.
//  Reset mid-operation discards all entries; no upd_en/redirect emitted afterwards.
// TESTING
//  T1 rst 2 cycles -> count=0, push_ready=1, upd_en=0, redirect_valid=0, err_underflow=0.
//  T2 push {pc_4=0x004,guess=0x004,st=01}; resolve branch taken target 0x040 -> next cycle upd_en=1,
//     upd_pc_4=0x004, upd_pc_remote=0x040, upd_state_old=01, upd_succ=1, redirect 0x040, count=0.
//  T3 push {0x010,0x080,st=11}; resolve branch taken 0x080 -> upd_en=1, upd_succ=1, redirect_valid=0.
//  T4 push 4 entries -> push_ready=0, 5th push ignored (count=4); resolve correct -> push_ready=1 next cycle;
//     push 4 more around wrap -> FIFO order preserved across wrap.
//  T5 3 in flight, head mispredicts (not-taken, guess 0x080, pc_4=0x00C) with push same cycle
//     -> redirect_pc=0x00C, count=0, pushed record absent.
//  T6 res_valid with empty queue -> err_underflow=1 sticky, upd_en=0; flush with 2 entries + push -> count=0.

Source files
------------

// File: rtl/bht_resolve_queue.sv
// In-order queue of fetch-time branch predictions, resolved oldest-first by EX.
// Each resolve drives a registered BHT update and, on a mispredict, a one-cycle redirect.
module bht_resolve_queue #(
    parameter int unsigned ADDR_W = 30,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [ADDR_W-1:0] push_pc_4,
    input  logic [ADDR_W-1:0] push_guess_pc,
    input  logic [1:0]        push_guess_st,
    input  logic              flush,
    input  logic              res_valid,
    input  logic              res_is_branch,
    input  logic              res_taken,
    input  logic [ADDR_W-1:0] res_target,
    output logic              upd_en,
    output logic [ADDR_W-1:0] upd_pc_4,
    output logic [ADDR_W-1:0] upd_pc_remote,
    output logic [1:0]        upd_state_old,
    output logic              upd_succ,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [CNT_W-1:0]  count,
    output logic              err_underflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [ADDR_W-1:0] pc4_mem   [DEPTH];
    logic [ADDR_W-1:0] guess_mem [DEPTH];
    logic [1:0]        st_mem    [DEPTH];

    logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              upd_en_q, upd_en_d;
    logic [ADDR_W-1:0] upd_pc_4_q, upd_pc_4_d;
    logic [ADDR_W-1:0] upd_pc_remote_q, upd_pc_remote_d;
    logic [1:0]        upd_state_old_q, upd_state_old_d;
    logic              upd_succ_q, upd_succ_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] head_pc4, head_guess, actual_pc;
    logic [1:0]        head_st;
    logic              empty, resolve, mispredict_now, push_acc;

    assign head_pc4   = pc4_mem[head_q];
    assign head_guess = guess_mem[head_q];
    assign head_st    = st_mem[head_q];

    assign empty          = (count_q == '0);
    assign push_ready     = (count_q < CNT_W'(DEPTH));
    assign resolve        = res_valid && !empty && !flush;
    assign actual_pc      = (res_is_branch && res_taken) ? res_target : head_pc4;
    assign mispredict_now = resolve && (actual_pc != head_guess);
    // Pushes arriving alongside a mispredict are wrong-path and must not survive.
    assign push_acc       = push_valid && push_ready && !flush && !mispredict_now;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush || mispredict_now) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (resolve) begin
                head_d = head_q + PtrW'(1);
            end
            if (push_acc) begin
                tail_d = tail_q + PtrW'(1);
            end
            count_d = count_q + CNT_W'(push_acc) - CNT_W'(resolve);
        end
    end

    always_comb begin
        upd_en_d         = 1'b0;
        redirect_valid_d = 1'b0;
        upd_pc_4_d       = upd_pc_4_q;
        upd_pc_remote_d  = upd_pc_remote_q;
        upd_state_old_d  = upd_state_old_q;
        upd_succ_d       = upd_succ_q;
        redirect_pc_d    = redirect_pc_q;
        err_d            = err_q | (res_valid && empty && !flush);
        if (resolve) begin
            upd_en_d         = res_is_branch;
            upd_pc_4_d       = head_pc4;
            upd_pc_remote_d  = res_taken ? res_target : head_guess;
            upd_state_old_d  = head_st;
            upd_succ_d       = res_taken;
            redirect_valid_d = mispredict_now;
            redirect_pc_d    = actual_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            upd_en_q         <= 1'b0;
            upd_pc_4_q       <= '0;
            upd_pc_remote_q  <= '0;
            upd_state_old_q  <= '0;
            upd_succ_q       <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            err_q            <= 1'b0;
        end else begin
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            upd_en_q         <= upd_en_d;
            upd_pc_4_q       <= upd_pc_4_d;
            upd_pc_remote_q  <= upd_pc_remote_d;
            upd_state_old_q  <= upd_state_old_d;
            upd_succ_q       <= upd_succ_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            err_q            <= err_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by head/tail/count.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            pc4_mem[tail_q]   <= push_pc_4;
            guess_mem[tail_q] <= push_guess_pc;
            st_mem[tail_q]    <= push_guess_st;
        end
    end

    assign upd_en         = upd_en_q;
    assign upd_pc_4       = upd_pc_4_q;
    assign upd_pc_remote  = upd_pc_remote_q;
    assign upd_state_old  = upd_state_old_q;
    assign upd_succ       = upd_succ_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign count          = count_q;
    assign err_underflow  = err_q;

endmodule

// File: tb/tb_bht_resolve_queue.sv
// Bench for bht_resolve_queue: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bht_resolve_queue;

    localparam int unsigned AW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          push_valid, push_ready;
    logic [AW-1:0] push_pc_4, push_guess_pc;
    logic [1:0]    push_guess_st;
    logic          flush, res_valid, res_is_branch, res_taken;
    logic [AW-1:0] res_target;
    logic          upd_en, upd_succ, redirect_valid, err_underflow;
    logic [AW-1:0] upd_pc_4, upd_pc_remote, redirect_pc;
    logic [1:0]    upd_state_old;
    logic [CW-1:0] count;

    int tests = 0;
    int fails = 0;
    bit started = 0;

    bht_resolve_queue #(.ADDR_W(AW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_pc_4(push_pc_4), .push_guess_pc(push_guess_pc), .push_guess_st(push_guess_st),
        .flush(flush),
        .res_valid(res_valid), .res_is_branch(res_is_branch), .res_taken(res_taken),
        .res_target(res_target),
        .upd_en(upd_en), .upd_pc_4(upd_pc_4), .upd_pc_remote(upd_pc_remote),
        .upd_state_old(upd_state_old), .upd_succ(upd_succ),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .count(count), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of in-flight records.
    typedef struct packed {
        logic [AW-1:0] pc4;
        logic [AW-1:0] guess;
        logic [1:0]    st;
    } rec_t;

    rec_t          mq[$];
    logic          e_en, e_succ, e_rv, e_err;
    logic [AW-1:0] e_pc4, e_rem, e_rpc;
    logic [1:0]    e_st;

    always @(posedge clk) begin
        rec_t          h;
        logic [AW-1:0] act;
        bit            mis;
        bit            was_full;
        if (rst) begin
            mq.delete();
            e_en = 0; e_succ = 0; e_rv = 0; e_err = 0;
            e_pc4 = '0; e_rem = '0; e_rpc = '0; e_st = '0;
        end else begin
            e_en = 0;
            e_rv = 0;
            mis = 0;
            was_full = (mq.size() >= DEPTH);
            if (flush) begin
                mq.delete();
            end else begin
                if (res_valid && mq.size() == 0) begin
                    e_err = 1;
                end else if (res_valid) begin
                    h = mq.pop_front();
                    act = (res_is_branch && res_taken) ? res_target : h.pc4;
                    mis = (act != h.guess);
                    e_en = res_is_branch;
                    e_pc4 = h.pc4;
                    e_rem = res_taken ? res_target : h.guess;
                    e_st = h.st;
                    e_succ = res_taken;
                    e_rv = mis;
                    e_rpc = act;
                    if (mis) mq.delete();
                end
                if (push_valid && !was_full && !mis)
                    mq.push_back('{pc4: push_pc_4, guess: push_guess_pc, st: push_guess_st});
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_count", 32'(count), 32'(mq.size()));
            chk("m_push_ready", 32'(push_ready), 32'(mq.size() < DEPTH));
            chk("m_upd_en", 32'(upd_en), 32'(e_en));
            chk("m_upd_pc_4", 32'(upd_pc_4), 32'(e_pc4));
            chk("m_upd_pc_remote", 32'(upd_pc_remote), 32'(e_rem));
            chk("m_upd_state_old", 32'(upd_state_old), 32'(e_st));
            chk("m_upd_succ", 32'(upd_succ), 32'(e_succ));
            chk("m_redirect_valid", 32'(redirect_valid), 32'(e_rv));
            chk("m_redirect_pc", 32'(redirect_pc), 32'(e_rpc));
            chk("m_err_underflow", 32'(err_underflow), 32'(e_err));
        end
    end

    task automatic idle();
        push_valid = 0; push_pc_4 = '0; push_guess_pc = '0; push_guess_st = '0;
        flush = 0; res_valid = 0; res_is_branch = 0; res_taken = 0; res_target = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        idle();
    endtask

    task automatic set_push(input logic [AW-1:0] pc, input logic [AW-1:0] g, input logic [1:0] st);
        push_valid = 1; push_pc_4 = pc; push_guess_pc = g; push_guess_st = st;
    endtask

    task automatic set_res(input logic br, input logic tk, input logic [AW-1:0] tgt);
        res_valid = 1; res_is_branch = br; res_taken = tk; res_target = tgt;
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (2) @(negedge clk);
        started = 1;
        // T1 reset state
        chk("t1_count", 32'(count), 0);
        chk("t1_push_ready", 32'(push_ready), 1);
        chk("t1_upd_en", 32'(upd_en), 0);
        chk("t1_redirect_valid", 32'(redirect_valid), 0);
        chk("t1_err", 32'(err_underflow), 0);
        rst = 0;

        // T2 predicted fall-through, branch taken -> mispredict
        set_push(16'h004, 16'h004, 2'b01); tick();
        set_res(1, 1, 16'h040); tick();
        chk("t2_upd_en", 32'(upd_en), 1);
        chk("t2_upd_pc_4", 32'(upd_pc_4), 32'h004);
        chk("t2_upd_pc_remote", 32'(upd_pc_remote), 32'h040);
        chk("t2_upd_state_old", 32'(upd_state_old), 1);
        chk("t2_upd_succ", 32'(upd_succ), 1);
        chk("t2_redirect_valid", 32'(redirect_valid), 1);
        chk("t2_redirect_pc", 32'(redirect_pc), 32'h040);
        chk("t2_count", 32'(count), 0);
        tick();
        chk("t2_redirect_pulse", 32'(redirect_valid), 0);

        // T3 correct taken prediction
        set_push(16'h010, 16'h080, 2'b11); tick();
        set_res(1, 1, 16'h080); tick();
        chk("t3_upd_en", 32'(upd_en), 1);
        chk("t3_upd_succ", 32'(upd_succ), 1);
        chk("t3_redirect_valid", 32'(redirect_valid), 0);
        chk("t3_upd_state_old", 32'(upd_state_old), 3);

        // T4 fill, overflow attempt, then traffic across the pointer wrap
        for (int i = 0; i < 4; i++) begin
            set_push(16'(16'h100 + 4 * i), 16'(16'h100 + 4 * i), 2'b00); tick();
        end
        chk("t4_full_ready", 32'(push_ready), 0);
        chk("t4_full_count", 32'(count), 4);
        set_push(16'h200, 16'h200, 2'b00); tick();
        chk("t4_overflow_count", 32'(count), 4);
        set_res(1, 0, 16'h0); tick();
        chk("t4_first_pc", 32'(upd_pc_4), 32'h100);
        chk("t4_ready_again", 32'(push_ready), 1);
        chk("t4_count3", 32'(count), 3);
        for (int i = 0; i < 3; i++) begin
            set_res(1, 0, 16'h0);
            set_push(16'(16'h110 + 4 * i), 16'(16'h110 + 4 * i), 2'b10);
            tick();
            chk("t4_order_a", 32'(upd_pc_4), 32'(16'h104 + 4 * i));
            chk("t4_count_steady", 32'(count), 3);
        end
        set_push(16'h11C, 16'h11C, 2'b10); tick();
        for (int i = 0; i < 4; i++) begin
            set_res(1, 0, 16'h0); tick();
            chk("t4_order_b", 32'(upd_pc_4), 32'(16'h110 + 4 * i));
            chk("t4_no_redirect", 32'(redirect_valid), 0);
        end
        chk("t4_drained", 32'(count), 0);

        // T5 head mispredict with same-cycle push
        set_push(16'h00C, 16'h080, 2'b10); tick();
        set_push(16'h010, 16'h010, 2'b00); tick();
        set_push(16'h014, 16'h014, 2'b00); tick();
        set_res(1, 0, 16'h0);
        set_push(16'h018, 16'h018, 2'b00);
        tick();
        chk("t5_redirect_valid", 32'(redirect_valid), 1);
        chk("t5_redirect_pc", 32'(redirect_pc), 32'h00C);
        chk("t5_upd_pc_remote", 32'(upd_pc_remote), 32'h080);
        chk("t5_count", 32'(count), 0);
        tick();
        chk("t5_push_dropped", 32'(count), 0);

        // Non-branch with aliased guess
        set_push(16'h020, 16'h030, 2'b01); tick();
        set_res(0, 0, 16'h0); tick();
        chk("alias_upd_en", 32'(upd_en), 0);
        chk("alias_redirect_valid", 32'(redirect_valid), 1);
        chk("alias_redirect_pc", 32'(redirect_pc), 32'h020);

        // T6 underflow and flush
        set_res(1, 1, 16'h050); tick();
        chk("t6_err", 32'(err_underflow), 1);
        chk("t6_upd_en", 32'(upd_en), 0);
        tick();
        chk("t6_err_sticky", 32'(err_underflow), 1);
        set_push(16'h030, 16'h030, 2'b00); tick();
        set_push(16'h034, 16'h034, 2'b00); tick();
        flush = 1; set_res(1, 1, 16'h060); set_push(16'h038, 16'h038, 2'b00); tick();
        chk("t6_flush_count", 32'(count), 0);
        chk("t6_flush_upd_en", 32'(upd_en), 0);
        chk("t6_flush_redirect", 32'(redirect_valid), 0);

        // Reset mid-operation
        set_push(16'h040, 16'h044, 2'b00); tick();
        set_push(16'h048, 16'h048, 2'b00); tick();
        rst = 1; tick();
        rst = 0; tick();
        chk("rst_mid_count", 32'(count), 0);
        chk("rst_mid_upd_en", 32'(upd_en), 0);
        chk("rst_mid_err", 32'(err_underflow), 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
